// File: rtl/tron_fb_pkg.sv
// Shared constants, colour names, FSM states and request payload for the frame writer.
package tron_fb_pkg;

  localparam int unsigned FB_W     = 640;
  localparam int unsigned FB_H     = 480;
  localparam int unsigned FB_WORDS = FB_W / 2 * FB_H;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DROP_W   = 8;

  typedef enum logic [COLOR_W-1:0] {
    BLACK      = 4'h0,
    RED_TRAIL  = 4'h3,
    RED_HEAD   = 4'h4,
    BLUE_TRAIL = 4'h5,
    BLUE_HEAD  = 4'h6,
    WALL       = 4'h8,
    BIKE_KEY   = 4'hF
  } color_e;

  typedef enum logic {
    IDLE,
    CLEAR
  } fw_state_e;

  // One queued pixel request: 24 bits {x, y, c}.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] c;
  } fw_req_t;

  // A word covers two horizontally adjacent pixels, both painted with c.
  function automatic logic [DATA_W-1:0] pack_word(input logic [COLOR_W-1:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

endpackage

// File: rtl/fw_req_fifo.sv
// Request FIFO for the frame writer.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, valid when !empty),
//        full/empty (registered flags). Push when full and pop when empty are ignored.
module fw_req_fifo
  import tron_fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  fw_req_t din,
  input  logic    pop,
  output fw_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fw_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers and flags; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; empty guards the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_writer.sv
// Write side of the colour-enum frame buffer: turns queued pixel requests into
// frameRAM word writes and can sweep the whole buffer with a clear colour.
// Ports: Clk, Reset (sync, active-high); clear_start/clear_color start a clear;
//        req_valid/req_ready/req_x/req_y/req_color pixel request handshake;
//        write_address/Data_In/WE registered frameRAM write port;
//        clearing (sweep active), clear_done (1-cycle pulse), drop_count (saturating).
// The row stride is the fixed 320-word shift-add, so FB_W is expected to stay 640;
// FB_H may be reduced for smaller buffers.
module frame_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FB_W       = tron_fb_pkg::FB_W,
  parameter int unsigned FB_H       = tron_fb_pkg::FB_H,
  parameter int unsigned FB_WORDS   = FB_W / 2 * FB_H
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             clear_start,
  input  logic [tron_fb_pkg::COLOR_W-1:0]  clear_color,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [tron_fb_pkg::COORD_W-1:0]  req_x,
  input  logic [tron_fb_pkg::COORD_W-1:0]  req_y,
  input  logic [tron_fb_pkg::COLOR_W-1:0]  req_color,
  output logic [tron_fb_pkg::ADDR_W-1:0]   write_address,
  output logic [tron_fb_pkg::DATA_W-1:0]   Data_In,
  output logic                             WE,
  output logic                             clearing,
  output logic                             clear_done,
  output logic [tron_fb_pkg::DROP_W-1:0]   drop_count
);

  import tron_fb_pkg::*;

  fw_state_e           state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                clearing_q, clearing_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [COLOR_W-1:0]  cc_q, cc_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  fw_req_t             push_req;
  fw_req_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                in_range;
  logic [ADDR_W-1:0]   pix_addr;

  assign push_req = '{x: req_x, y: req_y, c: req_color};
  assign req_ready = !fifo_full;

  fw_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (req_valid && !fifo_full),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Range check and word address of the FIFO head: x/2 + y*320.
  assign in_range = (head.x < COORD_W'(FB_W)) && (head.y < COORD_W'(FB_H));
  assign pix_addr = ADDR_W'(head.x >> 1) + (ADDR_W'(head.y) << 8) + (ADDR_W'(head.y) << 6);

  // Next state and next value of every registered output.
  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    clearing_d = clearing_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    cc_d       = cc_q;
    drop_d     = drop_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        // The final sweep write is on the port this cycle; end the sweep status next cycle.
        if (clearing_q) begin
          clearing_d = 1'b0;
          done_d     = 1'b1;
        end
        if (!fifo_empty) begin
          pop = 1'b1;
          if (in_range) begin
            we_d   = 1'b1;
            addr_d = pix_addr;
            data_d = pack_word(head.c);
          end else if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end
        if (clear_start) begin
          state_d    = CLEAR;
          cc_d       = clear_color;
          cnt_d      = '0;
          clearing_d = 1'b1;
        end
      end

      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = pack_word(cc_q);
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(FB_WORDS - 1)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      clearing_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      cc_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      clearing_q <= clearing_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      cc_q       <= cc_d;
      drop_q     <= drop_d;
    end
  end

  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;
  assign clearing      = clearing_q;
  assign clear_done    = done_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer with a reduced-height frame (640 x 20).
module tb_frame_writer;

  localparam int TB_H     = 20;
  localparam int TB_WORDS = 320 * TB_H;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        clear_start = 1'b0;
  logic [3:0]  clear_color = 4'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic [3:0]  req_color = '0;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic        WE;
  logic        clearing;
  logic        clear_done;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  frame_writer #(
    .FIFO_DEPTH (4),
    .FB_W       (640),
    .FB_H       (TB_H),
    .FB_WORDS   (TB_WORDS)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_color     (req_color),
    .write_address (write_address),
    .Data_In       (Data_In),
    .WE            (WE),
    .clearing      (clearing),
    .clear_done    (clear_done),
    .drop_count    (drop_count)
  );

  always #5 Clk = ~Clk;

  // Write/pulse recorder: cyc is the number of posedges seen so far.
  int unsigned cyc = 0;
  logic [18:0] wa_q[$];
  logic [15:0] wd_q[$];
  int unsigned wc_q[$];
  int unsigned done_q[$];

  always @(posedge Clk) begin
    #1;
    cyc = cyc + 1;
    if (WE === 1'b1) begin
      wa_q.push_back(write_address);
      wd_q.push_back(Data_In);
      wc_q.push_back(cyc);
    end
    if (clear_done === 1'b1) done_q.push_back(cyc);
  end

  // Reference rules: word = x/2 + y*320, both nibbles of the word carry the colour.
  function automatic logic [18:0] model_addr(input int x, input int y);
    return 19'(x / 2 + y * 320);
  endfunction

  function automatic logic [15:0] model_data(input int c);
    return 16'(c * 257);
  endfunction

  function automatic bit model_in_range(input int x, input int y);
    return (x < 640) && (y < TB_H);
  endfunction

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; req_valid = 1'b0; clear_start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic drive_req(input int x, input int y, input int c);
    req_x = 10'(x); req_y = 10'(y); req_color = 4'(c); req_valid = 1'b1;
  endtask

  // Wait (bounded) until clear_done has been seen.
  task automatic wait_done(input string name);
    int k = 0;
    while (done_q.size() == 0 && k < TB_WORDS + 100) begin
      @(negedge Clk);
      k++;
    end
    checks++;
    if (done_q.size() == 0) begin
      failures++;
      $display("FAIL %s: clear_done not seen within %0d cycles", name, TB_WORDS + 100);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", WE); end
    checks++; if (write_address !== 19'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", write_address); end
    checks++; if (Data_In !== 16'h0) begin failures++; $display("FAIL reset_data: got %h want 0000", Data_In); end
    checks++; if (clearing !== 1'b0 || clear_done !== 1'b0) begin failures++; $display("FAIL reset_clear_flags: got %b%b want 00", clearing, clear_done); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_pixel();
    int unsigned n;
    clear_log();
    @(negedge Clk);
    drive_req(101, 2, 3);
    n = cyc;
    @(negedge Clk); req_valid = 1'b0;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL pixel_early_we: got %b want 0", WE); end
    @(negedge Clk);
    checks++; if (WE !== 1'b1 || write_address !== 19'd690 || Data_In !== 16'h0303) begin
      failures++; $display("FAIL pixel_write: got we=%b addr=%0d data=%h want we=1 addr=690 data=0303", WE, write_address, Data_In);
    end
    @(negedge Clk);
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL pixel_we_after: got %b want 0", WE); end
    checks++; if (wc_q.size() != 1 || wc_q[0] != n + 2) begin
      failures++; $display("FAIL pixel_latency: got %0d writes want 1 at cycle %0d", wc_q.size(), n + 2);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    int xs[3] = '{0, 639, 2};
    int ys[3] = '{0, TB_H - 1, 0};
    int cs[3] = '{5, 6, 4};
    clear_log();
    @(negedge Clk); n = cyc;
    for (int i = 0; i < 3; i++) begin
      drive_req(xs[i], ys[i], cs[i]);
      @(negedge Clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge Clk);
    checks++;
    if (wa_q.size() != 3) begin
      failures++; $display("FAIL b2b_count: got %0d writes want 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[i] !== model_addr(xs[i], ys[i]) || wd_q[i] !== model_data(cs[i]) || wc_q[i] != n + 2 + i) begin
          failures++;
          $display("FAIL b2b_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   i, wa_q[i], wd_q[i], wc_q[i], model_addr(xs[i], ys[i]), model_data(cs[i]), n + 2 + i);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [18:0] ea[$];
    logic [15:0] ed[$];
    int drops;
    int x, y, c, bad;
    apply_reset();
    clear_log();
    drops = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
      end else begin
        x = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 639)) : int'($urandom_range(640, 1023));
        y = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TB_H - 1)) : int'($urandom_range(TB_H, 1023));
        c = int'($urandom_range(0, 15));
        drive_req(x, y, c);
        if (req_ready === 1'b1) begin
          if (model_in_range(x, y)) begin
            ea.push_back(model_addr(x, y));
            ed.push_back(model_data(c));
          end else if (drops < 255) begin
            drops++;
          end
        end
      end
    end
    @(negedge Clk); req_valid = 1'b0;
    repeat (10) @(negedge Clk);
    checks++;
    if (wa_q.size() != ea.size()) begin
      failures++; $display("FAIL random_count: got %0d writes want %0d", wa_q.size(), ea.size());
    end else begin
      bad = 0;
      foreach (ea[i]) if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL random_writes: got %0d mismatching writes want 0", bad); end
    end
    checks++; if (drop_count !== 8'(drops)) begin failures++; $display("FAIL random_drops: got %0d want %0d", drop_count, drops); end
  endtask

  task automatic test_drop_saturation();
    apply_reset();
    clear_log();
    @(negedge Clk); drive_req(640, 0, 3);
    @(negedge Clk); drive_req(0, TB_H, 3);
    @(negedge Clk); req_valid = 1'b0;
    repeat (4) @(negedge Clk);
    checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL drop_two: got %0d want 2", drop_count); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL drop_no_write: got %0d writes want 0", wa_q.size()); end
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (req_ready === 1'b1) drive_req(int'($urandom_range(640, 1023)), int'($urandom_range(0, 1023)), 3);
      else req_valid = 1'b0;
    end
    @(negedge Clk); req_valid = 1'b0;
    repeat (6) @(negedge Clk);
    checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL drop_sat_no_write: got %0d writes want 0", wa_q.size()); end
  endtask

  task automatic test_clear();
    int unsigned n;
    int bad;
    apply_reset();
    clear_log();
    @(negedge Clk); drive_req(10, 1, 3); n = cyc;
    @(negedge Clk); req_valid = 1'b0; clear_start = 1'b1; clear_color = 4'h8;
    @(negedge Clk); clear_start = 1'b0;
    checks++; if (clearing !== 1'b1) begin failures++; $display("FAIL clear_flag_rise: got %b want 1", clearing); end
    // A second start during the sweep must be ignored.
    repeat (100) @(negedge Clk);
    clear_start = 1'b1; clear_color = 4'h3;
    @(negedge Clk); clear_start = 1'b0;
    wait_done("clear_done_wait");
    repeat (5) @(negedge Clk);
    checks++;
    if (wa_q.size() != TB_WORDS + 1) begin
      failures++; $display("FAIL clear_count: got %0d writes want %0d", wa_q.size(), TB_WORDS + 1);
    end else begin
      checks++;
      if (wa_q[0] !== model_addr(10, 1) || wd_q[0] !== 16'h0303 || wc_q[0] != n + 2) begin
        failures++; $display("FAIL clear_pending_pixel: got addr=%0d data=%h cyc=%0d want addr=%0d data=0303 cyc=%0d",
                             wa_q[0], wd_q[0], wc_q[0], model_addr(10, 1), n + 2);
      end
      bad = 0;
      for (int i = 0; i < TB_WORDS; i++) begin
        if (wa_q[i+1] !== 19'(i) || wd_q[i+1] !== 16'h0808 || wc_q[i+1] != n + 3 + i) begin
          if (bad == 0) $display("FAIL clear_sweep_entry: index %0d got addr=%0d data=%h cyc=%0d want addr=%0d data=0808 cyc=%0d",
                                 i, wa_q[i+1], wd_q[i+1], wc_q[i+1], i, n + 3 + i);
          bad++;
        end
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL clear_sweep: got %0d bad entries want 0", bad); end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != n + 3 + TB_WORDS) begin
      failures++; $display("FAIL clear_done_pulse: got %0d pulses first at %0d want 1 at %0d",
                           done_q.size(), (done_q.size() > 0) ? done_q[0] : 0, n + 3 + TB_WORDS);
    end
    checks++; if (clearing !== 1'b0) begin failures++; $display("FAIL clear_flag_fall: got %b want 0", clearing); end
  endtask

  task automatic test_backpressure();
    logic [18:0] ea[4];
    logic [15:0] ed[4];
    int x, y, c, bad;
    clear_log();
    @(negedge Clk); clear_start = 1'b1; clear_color = 4'h0;
    @(negedge Clk); clear_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, TB_H - 1)); c = int'($urandom_range(1, 15));
      ea[i] = model_addr(x, y); ed[i] = model_data(c);
      drive_req(x, y, c);
      @(negedge Clk);
    end
    drive_req(0, 0, 15);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
    repeat (3) @(negedge Clk);
    checks++; if (req_ready !== 1'b0 || clearing !== 1'b1) begin
      failures++; $display("FAIL bp_hold: got ready=%b clearing=%b want ready=0 clearing=1", req_ready, clearing);
    end
    req_valid = 1'b0;
    wait_done("bp_done_wait");
    repeat (10) @(negedge Clk);
    checks++;
    if (wa_q.size() != TB_WORDS + 4) begin
      failures++; $display("FAIL bp_count: got %0d writes want %0d", wa_q.size(), TB_WORDS + 4);
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (wa_q[TB_WORDS + i] !== ea[i] || wd_q[TB_WORDS + i] !== ed[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_order: got %0d mismatching drained writes want 0", bad); end
    end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_clear();
    int k;
    int n0;
    clear_log();
    @(negedge Clk); clear_start = 1'b1; clear_color = 4'h5;
    @(negedge Clk); clear_start = 1'b0; drive_req(4, 4, 6);
    @(negedge Clk); drive_req(6, 4, 6);
    @(negedge Clk); req_valid = 1'b0;
    k = 0;
    while (!(wa_q.size() > 0 && wa_q[$] == 19'd5000) && k < TB_WORDS) begin
      @(negedge Clk);
      k++;
    end
    checks++;
    if (k >= TB_WORDS) begin
      failures++; $display("FAIL midclr_reach: address 5000 not seen within %0d cycles", TB_WORDS);
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (WE !== 1'b0 || clearing !== 1'b0 || req_ready !== 1'b1 || clear_done !== 1'b0) begin
      failures++; $display("FAIL midclr_reset_outputs: got we=%b clearing=%b ready=%b done=%b want 0 0 1 0",
                           WE, clearing, req_ready, clear_done);
    end
    Reset = 1'b0;
    n0 = wa_q.size();
    repeat (20) @(negedge Clk);
    checks++; if (wa_q.size() != n0) begin failures++; $display("FAIL midclr_flushed: got %0d writes after reset want 0", wa_q.size() - n0); end
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL midclr_no_done: got %0d pulses want 0", done_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_back_to_back();
    test_random();
    test_drop_saturation();
    test_clear();
    test_backpressure();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
